uart_rx_frontend: RTL and testbench
===================================

Name: uart_rx_frontend

Overview:
- Serial receive front end: turns the asynchronous rxd line into bytes for the loopback controller.
- Provides the rx_data / rx_empty / uld_rx_data handshake that the loopback FSM consumes.
- Does 8N1 framing with mid-bit 3-sample majority voting, false-start rejection, framing-error and overrun detection.
- One clock domain; rxd is synchronised internally.

Parameters:
- CLK_DIVISION, 443, clk cycles per bit period (minimum 8); H = CLK_DIVISION/2 (integer divide).
- SYNC_STAGES, 2, flip-flop stages on rx_in before any use (minimum 2).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high; all state cleared on the clk edge where reset=1
- rx_in  input  1  asynchronous serial line, idle high
- rx_enable  input  1  1 = receive; 0 = abort any frame and hold in IDLE
- uld_rx_data  input  1  consumer unload request; level or pulse
- rx_data  output  8  last accepted byte
- rx_empty  output  1  1 = no unread byte held; 0 = rx_data valid and unread
- frame_err  output  1  one-cycle pulse: stop bit sampled low
- overrun  output  1  one-cycle pulse: good byte dropped because previous byte unread
- busy  output  1  1 while FSM not in IDLE

Behaviour:
- Reset values: rx_data=8'h00, rx_empty=1, frame_err=0, overrun=0, busy=0, FSM=IDLE, sync chain all 1s.
- rs = synchronised rx_in (SYNC_STAGES cycles of latency). All logic below uses rs only.
- Bit-period counter cnt runs 0..CLK_DIVISION-1, then wraps to 0 and advances to the next bit. It is zeroed on entry to START.
- Samples are taken at cnt = H-1, H and H+1. The vote (2-of-3 majority) is evaluated on the H+1 edge, using the two stored samples plus the current rs.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: a 1->0 transition on rs with rx_enable=1 moves to START with cnt=0.
  - START: vote=1 (false start) -> IDLE on the vote edge. Vote=0 -> DATA when cnt wraps.
  - DATA: 8 bits, LSB first, voted into a shift register. After bit 7 wraps -> STOP.
  - STOP: on the vote edge:
    - vote=1 -> IDLE (half a bit early, allowing resync to the next start edge).
    - vote=0 -> frame_err pulse, byte discarded, -> WAIT_HIGH.
  - WAIT_HIGH: stay until rs=1, then -> IDLE. This prevents a break condition from being seen as repeated starts.
- Good-frame delivery happens on the STOP vote edge (same edge as the transition to IDLE):
  - rx_empty=1: rx_data<=byte, rx_empty<=0.
  - rx_empty=0 and uld_rx_data=0: byte dropped, overrun pulses, rx_data unchanged.
  - rx_empty=0 and uld_rx_data=1 on the same edge: unload and load coincide; rx_data<=new byte, rx_empty stays 0, no overrun.
- Unload: uld_rx_data=1 with rx_empty=0 and no simultaneous delivery -> rx_empty<=1 next edge; rx_data is held.
  - uld_rx_data while rx_empty=1 is ignored.
  - Holding uld_rx_data high continuously makes each delivered byte visible (rx_empty=0) for exactly one cycle.
- rx_enable=0: FSM forced to IDLE next edge; partial byte discarded; no flags raised. rx_data/rx_empty are unaffected and unload still works.
- Reset mid-frame: everything returns to reset values next edge. Reception restarts at the next falling edge seen after the sync chain refills with 1s.
- Latency: the rx_empty fall occurs SYNC_STAGES + 9*CLK_DIVISION + H+1 cycles after the start-bit falling edge on rx_in.
- frame_err and overrun are never asserted on the same edge.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined: frame is 8E1. A PARITY state is inserted between DATA and STOP, and the voted parity bit is checked for even parity over data+parity. Port parity_err (output, 1) is added: a one-cycle pulse on the STOP vote edge when parity fails. The byte is discarded (no load, no overrun). Framing error takes precedence: if both fail, only frame_err pulses.
- Undefined: 8N1 as above; no PARITY state, no parity_err port.

Test Plan:
- CLK_DIVISION=16, send 8'hA5 8N1 -> rx_data=8'hA5, rx_empty 1->0 at the computed latency, busy high during the frame. Then pulse uld_rx_data -> rx_empty=1 next edge, rx_data still 8'hA5.
- Idle line, drive rx_in low 4 cycles then high -> START vote=1, no byte, no flags, busy back to 0 within 16 cycles.
- Send 8'h3C with stop bit 0, hold line low 40 cycles -> one frame_err pulse, rx_empty stays 1, FSM in WAIT_HIGH until line high, then 8'h5A received correctly.
- Send 8'h11 then 8'h22 back-to-back, no unload -> rx_data=8'h11, one overrun pulse at the end of the second frame. Repeat with uld_rx_data=1 held -> both bytes delivered, no overrun.
- Send 8'hF0 with a 1-cycle inverted glitch at cnt=H of bit 2 -> majority corrects, rx_data=8'hF0. Assert reset at bit 4 of the next frame -> all outputs at reset values, following 8'h81 received cleanly.
- UART_RX_PARITY_EN defined: send 8'h07 with parity bit 1 -> received. Send with parity bit 0 -> parity_err pulse, rx_empty stays 1.

Source files
------------

// File: rtl/uart_rx_frontend.sv
// Serial receive front end: synchronised rxd, 8N1 framing with mid-bit 2-of-3 voting,
// false-start rejection, framing-error and overrun flags. Define UART_RX_PARITY_EN for 8E1.
module uart_rx_frontend #(
    parameter int CLK_DIVISION = 443,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_in,
    input  logic       rx_enable,
    input  logic       uld_rx_data,
    output logic [7:0] rx_data,
    output logic       rx_empty,
    output logic       frame_err,
    output logic       overrun,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       busy
);
    localparam int H     = CLK_DIVISION / 2;
    localparam int CNT_W = $clog2(CLK_DIVISION);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIVISION - 1);
    localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(H - 1);
    localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(H);
    localparam logic [CNT_W-1:0] CNT_VOTE = CNT_W'(H + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_HIGH
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   rs_prev_q, rs_prev_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_nxt;
    logic [2:0]             bit_q, bit_d;
    logic [7:0]             shift_q, shift_d;
    logic                   s0_q, s0_d, s1_q, s1_d;
    logic [7:0]             rx_data_q, rx_data_d;
    logic                   rx_empty_q, rx_empty_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
    logic                   par_q, par_d;
    logic                   parity_err_q, parity_err_d;
`endif
    logic                   rs, cnt_wrap, vote_edge, vote, deliver;

    assign rs = sync_q[SYNC_STAGES-1];

    // Timing points are named by the cnt value an edge produces: entry to START is the
    // cnt=0 edge, and the vote uses samples from the H-1 and H edges plus rs on the H+1 edge.
    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], rx_in};
        rs_prev_d   = rs;
        state_d     = state_q;
        cnt_wrap    = (cnt_q == CNT_LAST);
        cnt_nxt     = cnt_wrap ? '0 : cnt_q + 1'b1;
        cnt_d       = cnt_nxt;
        vote_edge   = (cnt_nxt == CNT_VOTE);
        vote        = (s0_q & s1_q) | (s0_q & rs) | (s1_q & rs);
        s0_d        = (cnt_nxt == CNT_S0) ? rs : s0_q;
        s1_d        = (cnt_nxt == CNT_S1) ? rs : s1_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_empty_d  = rx_empty_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        deliver     = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d        = par_q;
        parity_err_d = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rx_enable && rs_prev_q && !rs) begin
                    state_d = START;
                end
            end
            START: begin
                if (vote_edge && vote) begin
                    state_d = IDLE;
                end else if (cnt_wrap) begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                end
            end
            DATA: begin
                if (vote_edge) begin
                    shift_d = {vote, shift_q[7:1]};
                end
                if (cnt_wrap) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (vote_edge) begin
                    par_d = vote;
                end
                if (cnt_wrap) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (vote_edge) begin
                    if (!vote) begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_HIGH;
                    end else begin
                        // Leave half a bit early so the next start edge is caught cleanly.
                        state_d = IDLE;
`ifdef UART_RX_PARITY_EN
                        if (^{shift_q, par_q}) begin
                            parity_err_d = 1'b1;
                        end else begin
                            deliver = 1'b1;
                        end
`else
                        deliver = 1'b1;
`endif
                    end
                end
            end
            WAIT_HIGH: begin
                cnt_d = '0;
                if (rs) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (!rx_enable) begin
            state_d     = IDLE;
            cnt_d       = '0;
            frame_err_d = 1'b0;
            deliver     = 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_d = 1'b0;
`endif
        end

        // Handshake: rx_empty=0 means rx_data holds an unread byte; uld_rx_data high on an
        // edge with rx_empty=0 consumes it, and a delivery on that same edge replaces it.
        if (deliver) begin
            if (rx_empty_q || uld_rx_data) begin
                rx_data_d  = shift_q;
                rx_empty_d = 1'b0;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (uld_rx_data && !rx_empty_q) begin
            rx_empty_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sync_q      <= '1;
            rs_prev_q   <= 1'b1;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            s0_q        <= 1'b1;
            s1_q        <= 1'b1;
            rx_data_q   <= 8'h00;
            rx_empty_q  <= 1'b1;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            rs_prev_q   <= rs_prev_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            s0_q        <= s0_d;
            s1_q        <= s1_d;
            rx_data_q   <= rx_data_d;
            rx_empty_q  <= rx_empty_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_empty  = rx_empty_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Bench for uart_rx_frontend: frames are serialised from bytes and the outcome of each
// (load, overrun, framing or parity error, load time) is predicted from the frame rules.
`timescale 1ns/1ps
module tb_uart_rx_frontend;
    localparam int CD = 16;
    localparam int SS = 2;
    localparam int H  = CD / 2;
`ifdef UART_RX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    // Edges from the first edge that samples the start bit to the rx_empty fall.
    localparam int LAT = SS + (NB - 1) * CD + H + 1;

    logic       clk = 1'b0;
    logic       reset, rx_in, rx_enable, uld_rx_data;
    logic [7:0] rx_data;
    logic       rx_empty, frame_err, overrun, busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    uart_rx_frontend #(.CLK_DIVISION(CD), .SYNC_STAGES(SS)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_in      (rx_in),
        .rx_enable  (rx_enable),
        .uld_rx_data(uld_rx_data),
        .rx_data    (rx_data),
        .rx_empty   (rx_empty),
        .frame_err  (frame_err),
        .overrun    (overrun),
`ifdef UART_RX_PARITY_EN
        .parity_err (parity_err),
`endif
        .busy       (busy)
    );

    // ---------------- clock / cycle count ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    int         exp_t_q[$];
    logic       model_full = 1'b0;
    logic       uld_hold   = 1'b0;
    logic [7:0] last_byte  = 8'h00;
    int ferr_exp = 0, ovr_exp = 0, perr_exp = 0;
    int ferr_seen = 0, ovr_seen = 0, perr_seen = 0, both_seen = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- output monitor ----------------
    logic empty_prev = 1'b1;
    logic hold_chk   = 1'b0;
    always @(negedge clk) begin
        if (empty_prev && !rx_empty) begin
            if (exp_q.size() == 0) begin
                check("unexpected_load", 1, 0);
            end else begin
                check("rx_data_load", rx_data, exp_q.pop_front());
                check("load_cycle", cyc, exp_t_q.pop_front());
            end
        end
        if (hold_chk) check("uld_hold_one_cycle", rx_empty, 1);
        hold_chk = empty_prev && !rx_empty && uld_hold;
        if (frame_err) ferr_seen++;
        if (overrun) ovr_seen++;
        if (frame_err && overrun) both_seen++;
`ifdef UART_RX_PARITY_EN
        if (parity_err) perr_seen++;
`endif
        empty_prev = rx_empty;
    end

    // ---------------- driver tasks (entered and left on a falling clock edge) ----------------
    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip,
                              input int glitch_bit, input int rst_bit);
        logic [10:0] fr;
        int t0;
        fr = '1;
        fr[0] = 1'b0;
        fr[8:1] = b;
`ifdef UART_RX_PARITY_EN
        fr[9]  = (^b) ^ par_flip;
        fr[10] = stop_bit;
`else
        fr[9]  = stop_bit;
`endif
        t0 = cyc + 1;
        if (rst_bit < 0) begin
            if (!stop_bit) ferr_exp++;
            else if (par_flip) perr_exp++;
            else if (!model_full || uld_hold) begin
                exp_q.push_back(b);
                exp_t_q.push_back(t0 + LAT);
                model_full = !uld_hold;
                last_byte  = b;
            end else ovr_exp++;
        end
        for (int i = 0; i < NB; i++) begin
            for (int c = 0; c < CD; c++) begin
                rx_in = fr[i] ^ (glitch_bit >= 0 && i == glitch_bit + 1 && c == H);
                reset = (rst_bit >= 0 && i == rst_bit + 1 && c == 3);
                if (rst_bit < 0 && i == 4 && c == 0) check("busy_mid_frame", busy, 1);
                @(negedge clk);
                if (reset) begin
                    reset = 1'b0;
                    check("rst_mid_rx_data", rx_data, 8'h00);
                    check("rst_mid_rx_empty", rx_empty, 1);
                    check("rst_mid_busy", busy, 0);
                    check("rst_mid_flags", {frame_err, overrun}, 2'b00);
                    exp_q.delete();
                    exp_t_q.delete();
                    model_full = 1'b0;
                end
            end
        end
    endtask

    task automatic unload_pulse();
        uld_rx_data = 1'b1;
        @(negedge clk);
        uld_rx_data = 1'b0;
        check("unload_empty", rx_empty, 1);
        check("unload_rx_data_held", rx_data, last_byte);
        model_full = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] b;
        reset = 1'b1;
        rx_in = 1'b1;
        rx_enable = 1'b1;
        uld_rx_data = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_rx_empty", rx_empty, 1);
        check("reset_busy", busy, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_overrun", overrun, 0);
        reset = 1'b0;
        idle(10);

        // Basic frame, then unload.
        send_frame(8'hA5, 1'b1, 1'b0, -1, -1);
        idle(5);
        check("a5_held", rx_data, 8'hA5);
        unload_pulse();
        idle(5);

        // False start: a 4-cycle low blip.
        rx_in = 1'b0;
        repeat (4) @(negedge clk);
        rx_in = 1'b1;
        check("false_start_busy", busy, 1);
        repeat (16) @(negedge clk);
        check("false_start_idle", busy, 0);
        check("false_start_empty", rx_empty, 1);
        idle(10);

        // Framing error followed by a held-low break.
        send_frame(8'h3C, 1'b0, 1'b0, -1, -1);
        repeat (40) @(negedge clk);
        check("break_wait_high_busy", busy, 1);
        check("ferr_empty", rx_empty, 1);
        idle(20);
        check("break_released", busy, 0);
        send_frame(8'h5A, 1'b1, 1'b0, -1, -1);
        idle(5);
        unload_pulse();
        idle(5);

        // Back-to-back without unload: second byte overruns.
        send_frame(8'h11, 1'b1, 1'b0, -1, -1);
        send_frame(8'h22, 1'b1, 1'b0, -1, -1);
        idle(5);
        check("overrun_keeps_first", rx_data, 8'h11);
        unload_pulse();
        idle(5);

        // Back-to-back with unload held high: both bytes delivered.
        uld_hold = 1'b1;
        uld_rx_data = 1'b1;
        send_frame(8'h11, 1'b1, 1'b0, -1, -1);
        send_frame(8'h22, 1'b1, 1'b0, -1, -1);
        idle(5);
        uld_rx_data = 1'b0;
        uld_hold = 1'b0;
        check("hold_last_data", rx_data, 8'h22);
        idle(5);

        // Glitch in the middle of bit 2, then reset during bit 4 of the next frame.
        send_frame(8'hF0, 1'b1, 1'b0, 2, -1);
        idle(5);
        b = 8'hF0 | 8'($urandom_range(0, 15));
        send_frame(b, 1'b1, 1'b0, -1, 4);
        idle(30);
        check("post_reset_empty", rx_empty, 1);
        send_frame(8'h81, 1'b1, 1'b0, -1, -1);
        idle(5);
        unload_pulse();

        // Random frames with random gaps, glitches and occasional unloads.
        for (int k = 0; k < 8; k++) begin
            b = 8'($urandom_range(0, 255));
            send_frame(b, 1'b1, 1'b0, int'($urandom_range(0, 7)), -1);
            idle(int'($urandom_range(0, 12)));
            if (model_full && ($urandom_range(0, 1) == 1)) unload_pulse();
        end
        idle(5);
        if (model_full) unload_pulse();

`ifdef UART_RX_PARITY_EN
        idle(10);
        send_frame(8'h07, 1'b1, 1'b0, -1, -1);
        idle(5);
        unload_pulse();
        send_frame(8'h07, 1'b1, 1'b1, -1, -1);
        idle(5);
        check("parity_bad_empty", rx_empty, 1);
`endif

        idle(20);
        check("pending_loads", exp_q.size(), 0);
        check("frame_err_count", ferr_seen, ferr_exp);
        check("overrun_count", ovr_seen, ovr_exp);
        check("parity_err_count", perr_seen, perr_exp);
        check("ferr_ovr_same_edge", both_seen, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
